imem_arbiter: RTL and testbench

Shares the single-port instruction on-chip memory (10-bit word address, 32-bit data, byte enables, fixed read latency) between the core's instruction-fetch port and the program loader/debug port. It sits between the fetch stage and the memory's s1 slave, and sequences a safe handover into an exclusive loader mode for program download. At most one memory access is issued per cycle. Read data is routed back to the requester that issued the read.

---
 rtl/imem_arbiter_pkg.sv | 26 ++
 rtl/imem_rd_tagpipe.sv | 49 ++++
 rtl/imem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_imem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared types for the instruction-memory arbiter: mode FSM states,
// read-return owner tags and the legal memory read-latency range.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN_F = 2'd1,
        LOAD    = 2'd2,
        DRAIN_L = 2'd3
    } mode_e;

    typedef enum logic {
        FETCH = 1'b0,
        LDR   = 1'b1
    } owner_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    function automatic int unsigned rd_lat_clamp(int unsigned lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/imem_rd_tagpipe.sv
// Read-return tag pipeline: shifts {valid, owner} one stage per cycle.
// Ports: clk_i, flush_i (sync clear), push_*_i (stage 0 input),
// out_*_o (last stage), inflight_o / fetch_inflight_o (any valid entry).
module imem_rd_tagpipe
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic   clk_i,
    input  logic   flush_i,
    input  logic   push_vld_i,
    input  owner_e push_own_i,
    output logic   out_vld_o,
    output owner_e out_own_o,
    output logic   inflight_o,
    output logic   fetch_inflight_o
);

    // own bit: 1 = loader, 0 = fetch
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] own_q, own_d;

    always_comb begin
        vld_d    = vld_q;
        own_d    = own_q;
        vld_d[0] = push_vld_i;
        own_d[0] = (push_own_i == LDR);
        for (int i = 1; i < int'(DEPTH); i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    assign out_vld_o        = vld_q[DEPTH-1];
    assign out_own_o        = own_q[DEPTH-1] ? LDR : FETCH;
    assign inflight_o       = |vld_q;
    assign fetch_inflight_o = |(vld_q & ~own_q);

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between fetch and loader,
// with a drain-sequenced exclusive loader mode.
// Ports: clk_clk/reset_reset; fetch_* read port; ldr_* read/write port;
// ldr_mode/ldr_mode_ack handover; mem_* drive the memory s1 slave.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic                fetch_req,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic                fetch_gnt,
    output logic                fetch_rvalid,
    output logic [DATA_W-1:0]   fetch_rdata,
    input  logic                ldr_req,
    input  logic                ldr_we,
    input  logic [ADDR_W-1:0]   ldr_addr,
    input  logic [DATA_W-1:0]   ldr_wdata,
    input  logic [DATA_W/8-1:0] ldr_be,
    output logic                ldr_gnt,
    output logic                ldr_rvalid,
    output logic [DATA_W-1:0]   ldr_rdata,
    input  logic                ldr_mode,
    output logic                ldr_mode_ack,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_clken,
    output logic                mem_debugaccess,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    // Out-of-range latencies fall back to the nearest legal depth.
    localparam int unsigned DEPTH = rd_lat_clamp(RD_LATENCY);

    mode_e  state_q, state_d;
    owner_e last_q, last_d;

    logic f_cand, l_cand;
    logic f_win, l_win;
    logic push_vld;
    owner_e push_own;

    logic   tp_out_vld;
    owner_e tp_out_own;
    logic   tp_inflight;
    logic   tp_f_inflight;

    logic              f_rvalid_q, f_rvalid_d;
    logic              l_rvalid_q, l_rvalid_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d;
    logic [DATA_W-1:0] l_rdata_q, l_rdata_d;

    // Grants are suppressed during reset so no access reaches memory.
    always_comb begin
        f_cand = 1'b0;
        l_cand = 1'b0;
        if (!reset_reset) begin
            f_cand = fetch_req && (state_q == RUN);
            l_cand = ldr_req && (state_q != DRAIN_L);
        end
    end

    always_comb begin
        f_win  = 1'b0;
        l_win  = 1'b0;
        last_d = last_q;
        if (f_cand && l_cand) begin
            f_win = (last_q == LDR);
            l_win = (last_q == FETCH);
        end else begin
            f_win = f_cand;
            l_win = l_cand;
        end
        if (f_win) last_d = FETCH;
        if (l_win) last_d = LDR;
    end

    always_comb begin
        push_vld = f_win || (l_win && !ldr_we);
        push_own = l_win ? LDR : FETCH;
    end

    always_comb begin
        mem_address     = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_writedata   = '0;
        mem_byteenable  = '0;
        mem_debugaccess = 1'b0;
        if (f_win) begin
            mem_address    = fetch_addr;
            mem_chipselect = 1'b1;
            mem_byteenable = {BE_W{1'b1}};
        end else if (l_win) begin
            mem_address     = ldr_addr;
            mem_chipselect  = 1'b1;
            mem_write       = ldr_we;
            mem_writedata   = ldr_we ? ldr_wdata : '0;
            mem_byteenable  = ldr_be;
            mem_debugaccess = ldr_we;
        end
    end

    assign mem_clken = 1'b1;
    assign fetch_gnt = f_win;
    assign ldr_gnt   = l_win;

    // Drains wait on the tags already issued; no new grant can
    // re-fill them (DRAIN_F blocks fetch, DRAIN_L blocks all).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (ldr_mode) state_d = DRAIN_F;
            DRAIN_F: if (!tp_f_inflight) state_d = LOAD;
            LOAD:    if (!ldr_mode) state_d = DRAIN_L;
            DRAIN_L: if (!tp_inflight) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign ldr_mode_ack = (state_q == LOAD);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= RUN;
            last_q  <= LDR;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    imem_rd_tagpipe #(
        .DEPTH (DEPTH)
    ) u_tagpipe (
        .clk_i            (clk_clk),
        .flush_i          (reset_reset),
        .push_vld_i       (push_vld),
        .push_own_i       (push_own),
        .out_vld_o        (tp_out_vld),
        .out_own_o        (tp_out_own),
        .inflight_o       (tp_inflight),
        .fetch_inflight_o (tp_f_inflight)
    );

    always_comb begin
        f_rvalid_d = tp_out_vld && (tp_out_own == FETCH);
        l_rvalid_d = tp_out_vld && (tp_out_own == LDR);
        f_rdata_d  = f_rvalid_d ? mem_readdata : f_rdata_q;
        l_rdata_d  = l_rvalid_d ? mem_readdata : l_rdata_q;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
            f_rdata_q  <= '0;
            l_rdata_q  <= '0;
        end else begin
            f_rvalid_q <= f_rvalid_d;
            l_rvalid_q <= l_rvalid_d;
            f_rdata_q  <= f_rdata_d;
            l_rdata_q  <= l_rdata_d;
        end
    end

    assign fetch_rvalid = f_rvalid_q;
    assign fetch_rdata  = f_rdata_q;
    assign ldr_rvalid   = l_rvalid_q;
    assign ldr_rdata    = l_rdata_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 1-cycle-latency memory model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req;
    logic [9:0]  f_addr;
    logic        f_gnt, f_rv;
    logic [31:0] f_rd;
    logic        l_req, l_we;
    logic [9:0]  l_addr;
    logic [31:0] l_wd;
    logic [3:0]  l_be;
    logic        l_gnt, l_rv;
    logic [31:0] l_rd;
    logic        l_mode, l_ack;
    logic [9:0]  m_addr;
    logic        m_cs, m_we, m_clken, m_dbg;
    logic [31:0] m_wd, m_rd;
    logic [3:0]  m_be;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    imem_arbiter dut (
        .clk_clk         (clk),
        .reset_reset     (rst),
        .fetch_req       (f_req),
        .fetch_addr      (f_addr),
        .fetch_gnt       (f_gnt),
        .fetch_rvalid    (f_rv),
        .fetch_rdata     (f_rd),
        .ldr_req         (l_req),
        .ldr_we          (l_we),
        .ldr_addr        (l_addr),
        .ldr_wdata       (l_wd),
        .ldr_be          (l_be),
        .ldr_gnt         (l_gnt),
        .ldr_rvalid      (l_rv),
        .ldr_rdata       (l_rd),
        .ldr_mode        (l_mode),
        .ldr_mode_ack    (l_ack),
        .mem_address     (m_addr),
        .mem_chipselect  (m_cs),
        .mem_write       (m_we),
        .mem_writedata   (m_wd),
        .mem_byteenable  (m_be),
        .mem_clken       (m_clken),
        .mem_debugaccess (m_dbg),
        .mem_readdata    (m_rd)
    );

    always @(posedge clk) begin
        if (m_cs) begin
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_be[b])
                        mem[m_addr][8*b +: 8] <= m_wd[8*b +: 8];
            end
            m_rd <= mem[m_addr];
        end
    end

    function automatic logic [31:0] pat(input int a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        f_req = 0; l_req = 0; l_we = 0;
        f_addr = 0; l_addr = 0; l_wd = 0; l_be = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fgnt"}, f_gnt, 0);
        chk({tag, "_lgnt"}, l_gnt, 0);
        chk({tag, "_frv"}, f_rv, 0);
        chk({tag, "_lrv"}, l_rv, 0);
        chk({tag, "_frd"}, f_rd, 0);
        chk({tag, "_lrd"}, l_rd, 0);
        chk({tag, "_ack"}, l_ack, 0);
        chk({tag, "_cs"}, m_cs, 0);
        chk({tag, "_we"}, m_we, 0);
        chk({tag, "_be"}, m_be, 0);
        chk({tag, "_dbg"}, m_dbg, 0);
        chk({tag, "_clken"}, m_clken, 1);
    endtask

    task automatic do_reset();
        tick(); rst = 1; idle(); l_mode = 0;
        tick(); tick(); #1;
        chk_reset_vals("rst");
        rst = 0;
    endtask

    initial begin
        m_rd = 0;
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem[4]     = 32'h0000_0013;
        mem[10'h3FF] = 32'hFFFF_FFFF;
        rst = 1; idle(); l_mode = 0;
        do_reset();

        // single fetch read
        tick(); f_req = 1; f_addr = 10'h004; #1;
        chk("f1_gnt", f_gnt, 1);
        chk("f1_cs", m_cs, 1);
        chk("f1_addr", m_addr, 10'h004);
        chk("f1_be", m_be, 4'hF);
        chk("f1_we", m_we, 0);
        tick(); f_req = 0; #1;
        chk("f1_rv_early", f_rv, 0);
        tick(); #1;
        chk("f1_rv", f_rv, 1);
        chk("f1_rd", f_rd, 32'h0000_0013);
        tick(); #1;
        chk("f1_rv_off", f_rv, 0);
        chk("f1_rd_hold", f_rd, 32'h0000_0013);

        // both requesting: fetch, loader, fetch, loader
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            f_req = (k < 4); l_req = (k < 4);
            l_we = 0; l_be = 4'hF;
            f_addr = 10'(16 + k); l_addr = 10'(32 + k);
            #1;
            chk($sformatf("rr_fgnt%0d", k), f_gnt, (k < 4) && (k % 2 == 0));
            chk($sformatf("rr_lgnt%0d", k), l_gnt, (k < 4) && (k % 2 == 1));
            if (k >= 2) begin
                chk($sformatf("rr_frv%0d", k), f_rv, (k % 2 == 0));
                chk($sformatf("rr_lrv%0d", k), l_rv, (k % 2 == 1));
                if (k % 2 == 0)
                    chk($sformatf("rr_frd%0d", k), f_rd, pat(16 + k - 2));
                else
                    chk($sformatf("rr_lrd%0d", k), l_rd, pat(32 + k - 2));
            end
        end
        idle();

        // partial loader write, then read back
        tick(); l_req = 1; l_we = 1; l_addr = 10'h3FF;
        l_wd = 32'hDEAD_BEEF; l_be = 4'b0011; #1;
        chk("w_gnt", l_gnt, 1);
        chk("w_we", m_we, 1);
        chk("w_dbg", m_dbg, 1);
        chk("w_be", m_be, 4'b0011);
        chk("w_wd", m_wd, 32'hDEAD_BEEF);
        chk("w_addr", m_addr, 10'h3FF);
        tick(); l_we = 0; l_be = 4'hF; l_wd = 0; #1;
        chk("r_gnt", l_gnt, 1);
        chk("r_we", m_we, 0);
        chk("r_dbg", m_dbg, 0);
        tick(); idle(); #1;
        chk("w_no_rv", l_rv, 0);
        chk("r_dbg_idle", m_dbg, 0);
        tick(); #1;
        chk("r_rv", l_rv, 1);
        chk("r_rd", l_rd, 32'hFFFF_BEEF);

        // enter loader mode with a fetch read just granted
        tick(); f_req = 1; f_addr = 10'h004; l_mode = 1; #1;
        chk("m0_fgnt", f_gnt, 1);
        chk("m0_ack", l_ack, 0);
        tick(); l_req = 1; l_addr = 10'h005; l_be = 4'hF; #1;
        chk("m1_fgnt", f_gnt, 0);
        chk("m1_lgnt", l_gnt, 1);
        chk("m1_ack", l_ack, 0);
        tick(); l_req = 0; #1;
        chk("m2_frv", f_rv, 1);
        chk("m2_frd", f_rd, 32'h0000_0013);
        chk("m2_fgnt", f_gnt, 0);
        chk("m2_ack", l_ack, 0);
        tick(); l_req = 1; l_addr = 10'h3FF; #1;
        chk("m3_ack", l_ack, 1);
        chk("m3_fgnt", f_gnt, 0);
        chk("m3_lgnt", l_gnt, 1);
        chk("m3_lrv", l_rv, 1);
        chk("m3_lrd", l_rd, pat(5));

        // leave loader mode with a loader read in flight
        tick(); l_addr = 10'h006; l_mode = 0; #1;
        chk("m4_ack", l_ack, 1);
        chk("m4_lgnt", l_gnt, 1);
        chk("m4_fgnt", f_gnt, 0);
        tick(); l_req = 0; #1;
        chk("d0_fgnt", f_gnt, 0);
        chk("d0_lgnt", l_gnt, 0);
        chk("d0_ack", l_ack, 0);
        chk("d0_lrv", l_rv, 1);
        chk("d0_lrd", l_rd, 32'hFFFF_BEEF);
        tick(); l_req = 1; #1;
        chk("d1_fgnt", f_gnt, 0);
        chk("d1_lgnt", l_gnt, 0);
        chk("d1_lrv", l_rv, 1);
        chk("d1_lrd", l_rd, pat(6));
        tick(); l_req = 0; #1;
        chk("run_fgnt", f_gnt, 1);
        chk("run_ack", l_ack, 0);

        // reset one cycle after the read grant
        tick(); rst = 1; idle(); #1;
        chk("rp_fgnt", f_gnt, 0);
        tick(); rst = 0; #1;
        chk_reset_vals("rp");
        tick(); #1;
        chk("rp_frv_late", f_rv, 0);
        chk("rp_lrv_late", l_rv, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
